core_mem_arb: RTL

CORE_MEM_ARB -- requirements
Module: core_mem_arb

---
 rtl/core_mem_arb_if.sv | 49 ++++
 rtl/core_mem_arb.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/core_mem_arb_if.sv
// -----------------------------------------------------------------------------
// core_mem_arb_if
// Bundles the per-channel request bus and the shared response bus of
// core_mem_arb.
//   master modport : core side. Drives requests, receives ack and responses.
//   slave  modport : arbiter side (core_mem_arb).
// Signals:
//   req_val/req_ack/req_we [NCH]     per-channel handshake and write enable
//   req_addr  [NCH*AW]               channel i in bits [i*AW +: AW]
//   req_wdata [NCH*DW], req_be [NCH*DW/8]
//   resp_val  [NCH]                  one-cycle response pulse per channel
//   resp_rdata[DW]                   shared read data, 0 when no response
//   resp_err                         only when CORE_MEM_ARB_ERR_EN is defined
// -----------------------------------------------------------------------------
interface core_mem_arb_if #(
    parameter int NCH = 2,
    parameter int AW  = 32,
    parameter int DW  = 32
);
    logic [NCH-1:0]      req_val;
    logic [NCH-1:0]      req_ack;
    logic [NCH-1:0]      req_we;
    logic [NCH*AW-1:0]   req_addr;
    logic [NCH*DW-1:0]   req_wdata;
    logic [NCH*DW/8-1:0] req_be;
    logic [NCH-1:0]      resp_val;
    logic [DW-1:0]       resp_rdata;
`ifdef CORE_MEM_ARB_ERR_EN
    logic                resp_err;

    modport master (
        output req_val, req_we, req_addr, req_wdata, req_be,
        input  req_ack, resp_val, resp_rdata, resp_err
    );
    modport slave (
        input  req_val, req_we, req_addr, req_wdata, req_be,
        output req_ack, resp_val, resp_rdata, resp_err
    );
`else
    modport master (
        output req_val, req_we, req_addr, req_wdata, req_be,
        input  req_ack, resp_val, resp_rdata
    );
    modport slave (
        input  req_val, req_we, req_addr, req_wdata, req_be,
        output req_ack, resp_val, resp_rdata
    );
`endif
endinterface

// File: rtl/core_mem_arb.sv
// -----------------------------------------------------------------------------
// core_mem_arb
// Round-robin arbiter for NCH core request channels (0 = instruction,
// 1 = data) in front of a single-port, byte-writable word memory. One request
// is accepted per cycle; its response comes back exactly LAT cycles later
// through a fully pipelined response path.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset (memory contents are kept)
//   bus  : core_mem_arb_if.slave (requests, acks, responses)
// Optional feature macro: CORE_MEM_ARB_ERR_EN -- adds resp_err and rejects
// addresses with nonzero bits above the word-index field. Without it, upper
// address bits are ignored and the address wraps modulo DEPTH words.
// -----------------------------------------------------------------------------
module core_mem_arb #(
    parameter int NCH   = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int LAT   = 1
) (
    input logic           clk,
    input logic           rst,
    core_mem_arb_if.slave bus
);
    localparam int NB   = DW / 8;
    localparam int OFFW = $clog2(NB);
    localparam int IW   = $clog2(DEPTH);
    localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef CORE_MEM_ARB_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct packed {
        logic           v;     // response pending in this stage
        logic [CHW-1:0] ch;    // channel to answer
        logic           z;     // force zero data (write or rejected access)
        logic           err;   // out-of-range access
    } ctl_t;

    logic [CHW-1:0] ptr_reg;
    logic [NCH-1:0] grant;
    logic [CHW-1:0] gnt_idx;
    logic           gnt_any;
    logic           acc;
    logic           sel_we;
    logic [DW-1:0]  sel_wdata;
    logic [NB-1:0]  sel_be;
    logic [IW-1:0]  sel_idx;
    logic           oor;
    logic           wr_en;
    ctl_t           ctl_in;
    ctl_t           ctl_out;
    logic [DW-1:0]  data_out;

    logic [DW-1:0]  mem [DEPTH];

    // ---------------- arbitration ----------------
    genvar gi;
    generate
        if (NCH == 1) begin : g_single
            always_comb begin
                grant   = bus.req_val;
                gnt_idx = '0;
                gnt_any = bus.req_val[0];
            end
        end else begin : g_rr
            // Scan channels starting at the round-robin pointer; first requester wins.
            always_comb begin
                int c;
                grant   = '0;
                gnt_idx = '0;
                gnt_any = 1'b0;
                c       = 0;
                for (int off = 0; off < NCH; off++) begin
                    c = int'(ptr_reg) + off;
                    if (c >= NCH) c = c - NCH;
                    if (!gnt_any && bus.req_val[c]) begin
                        gnt_any  = 1'b1;
                        gnt_idx  = CHW'(c);
                        grant[c] = 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Nothing is accepted while reset is held, not even combinationally.
    assign bus.req_ack = grant & {NCH{rst}};
    assign acc         = gnt_any & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= '0;
        end else if (acc) begin
            ptr_reg <= (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // ---------------- winning request fields ----------------
    assign sel_we    = bus.req_we[gnt_idx];
    assign sel_wdata = bus.req_wdata[gnt_idx*DW +: DW];
    assign sel_be    = bus.req_be[gnt_idx*NB +: NB];
    assign sel_idx   = bus.req_addr[gnt_idx*AW + OFFW +: IW];
    assign oor       = ERR_EN && ((bus.req_addr[gnt_idx*AW +: AW] >> (OFFW + IW)) != '0);
    assign wr_en     = acc & sel_we & ~oor;

    // ---------------- memory (no reset: contents survive rst) ----------------
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NB; b++) begin
                if (sel_be[b]) mem[sel_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        ctl_in     = '0;
        ctl_in.v   = acc;
        ctl_in.ch  = gnt_idx;
        ctl_in.z   = sel_we | oor;
        ctl_in.err = oor;
    end

    // ---------------- response pipeline, LAT stages ----------------
    // Stage 0 data is the registered memory read taken at the ack edge.
    // Data registers are not reset; the output is gated by the control bits.
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            ctl_t          ctl_reg;
            ctl_t          ctl_prev;
            logic [DW-1:0] data_reg;

            if (gi == 0) begin : g_first
                assign ctl_prev = ctl_in;
                always_ff @(posedge clk) begin
                    data_reg <= mem[sel_idx];
                end
            end else begin : g_next
                assign ctl_prev = g_stage[gi-1].ctl_reg;
                always_ff @(posedge clk) begin
                    data_reg <= g_stage[gi-1].data_reg;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) ctl_reg <= '0;
                else      ctl_reg <= ctl_prev;
            end
        end
    endgenerate

    assign ctl_out  = g_stage[LAT-1].ctl_reg;
    assign data_out = g_stage[LAT-1].data_reg;

    always_comb begin
        bus.resp_val   = '0;
        bus.resp_rdata = '0;
        if (ctl_out.v) begin
            bus.resp_val[ctl_out.ch] = 1'b1;
            if (!ctl_out.z) bus.resp_rdata = data_out;
        end
    end

`ifdef CORE_MEM_ARB_ERR_EN
    assign bus.resp_err = ctl_out.v & ctl_out.err;
`endif

endmodule
